mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register. Consumes the registered ALU result, store data, destination register and MEM/WB control bits. Performs a handshaked data-memory read or write, stalling upstream while the access is outstanding. Presents the write-back triple (data, register, enable) to the register file.

## Interface
- TIMEOUT, 15: max ACCESS cycles waiting for dmem_ack before abort (1..15; 4-bit counter)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
- in_alu_result  in  8  ALU result; memory address for loads/stores
- in_data_2  in  8  store data
- in_reg_write  in  3  destination register
- in_MEM_mem_read_write  in  1  1 = store, 0 = no store
- in_WB_mem_or_alu  in  1  1 = load (write-back from memory), 0 = ALU
- in_WB_reg_write_signal  in  1  instruction writes the register file
- stall  out  1  combinational; 1 = upstream must hold its outputs
- dmem_req  out  1  registered memory request
- dmem_we  out  1  registered; 1 = write
- dmem_addr  out  8  registered address
- dmem_wdata  out  8  registered write data
- dmem_rdata  in  8  read data, valid when dmem_ack = 1
- dmem_ack  in  1  memory completion, one-cycle pulse
- out_wb_data  out  8  write-back data
- out_wb_reg  out  3  write-back register
- out_wb_we  out  1  register-file write enable
- err  out  1  sticky: memory access timed out

## Operation
- Mem op = in_valid & (in_MEM_mem_read_write | in_WB_mem_or_alu). If both bits are set, the op is a store; the load bit is ignored.
- States: IDLE, ACCESS. stall = (state == ACCESS).
- IDLE, edge with in_valid & non-mem op:
  - out_wb_data <= in_alu_result, out_wb_reg <= in_reg_write, out_wb_we <= in_WB_reg_write_signal.
  - Stay in IDLE.
- IDLE, edge with mem op:
  - dmem_req <= 1, dmem_we <= store, dmem_addr <= in_alu_result, dmem_wdata <= in_data_2.
  - Hold reg_write, reg_write_signal and load/store type internally.
  - out_wb_we <= 0; counter <= 0; go to ACCESS.
- IDLE, edge with in_valid = 0: out_wb_we <= 0; data and reg outputs keep their values.
- ACCESS: dmem_req/we/addr/wdata stay stable; in_* are ignored.
- ACCESS, edge with dmem_ack = 1:
  - dmem_req <= 0, dmem_we <= 0; go to IDLE.
  - Load: out_wb_data <= dmem_rdata, out_wb_reg <= held reg, out_wb_we <= held reg_write_signal.
  - Store: out_wb_we <= 0.
- ACCESS, edge with no ack: counter <= counter + 1.
  - If counter == TIMEOUT-1: abort. dmem_req <= 0, dmem_we <= 0, out_wb_we <= 0, err <= 1, go to IDLE.
- dmem_ack in IDLE: ignored. err clears only on reset.

## Timing
- Reset (async, immediate): state IDLE, counter 0, and every output 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, out_wb_data, out_wb_reg, out_wb_we, err). stall = 0 follows.
- Non-mem op: write-back outputs valid 1 cycle after the accepting edge; no stall.
- Mem op accepted at edge E0: dmem_req high from E0.
  - Ack sampled at edge Ek (k >= 1) gives write-back visible after Ek.
  - stall is high from E0 until Ek, low the cycle after.
  - The upstream instruction held during the stall is accepted at Ek+1: one bubble on out_wb_we per access.
- Fastest access: ack in the first ACCESS cycle (k = 1); stall high 1 cycle.
- Timeout: ack is sampled on ACCESS cycles 1..TIMEOUT. Abort at edge E_TIMEOUT.
- Ack on the same edge as timeout: ack wins; err unchanged.
- Reset mid-ACCESS: request dropped immediately; the in-flight op is lost; no write-back.

## Test plan
- ALU op: in_valid=1, alu=0x3C, reg=5, rw=1 -> next cycle out_wb_data=0x3C, out_wb_reg=5, out_wb_we=1, stall never high.
- Load, ack after 3 cycles with rdata=0xA5, addr=0x10, reg=2 -> dmem_req=1, dmem_we=0, dmem_addr=0x10 for 3 cycles; stall high 3 cycles; then out_wb_data=0xA5, reg=2, we=1.
- Store addr=0x20, data=0x77, ack after 1 cycle -> dmem_we=1, dmem_wdata=0x77; out_wb_we stays 0; following ALU op written back 2 cycles after the store is accepted.
- Back-to-back loads with upstream honoring stall -> both results written back in order; no instruction dropped or duplicated.
- No ack, TIMEOUT=15 -> dmem_req high exactly 15 cycles, then err=1, out_wb_we=0, IDLE. Variant: ack on cycle 15 -> err=0, result written.
- rst_n pulled low during ACCESS -> dmem_req, stall, out_wb_we and err all 0 immediately; the next op after release behaves normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register.
// It issues one handshaked data-memory access per load or store and stalls
// upstream while that access is outstanding. It then presents the write-back
// triple (data, register, enable) to the register file.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_alu_result,
    input  logic [7:0] in_data_2,
    input  logic [2:0] in_reg_write,
    input  logic       in_MEM_mem_read_write,
    input  logic       in_WB_mem_or_alu,
    input  logic       in_WB_reg_write_signal,
    output logic       stall,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic [7:0] dmem_rdata,
    input  logic       dmem_ack,
    output logic [7:0] out_wb_data,
    output logic [2:0] out_wb_reg,
    output logic       out_wb_we,
    output logic       err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [REG_W-1:0]    wb_reg_q, wb_reg_d;
    logic                wb_we_q, wb_we_d;
    logic                err_q, err_d;
    logic [REG_W-1:0]    hold_reg_q, hold_reg_d;
    logic                hold_rw_q, hold_rw_d;
    logic                hold_load_q, hold_load_d;

    logic                is_store;
    logic                mem_op;

    // If the store and load bits are both set, the instruction is a store.
    assign is_store = in_MEM_mem_read_write;
    assign mem_op   = in_valid & (in_MEM_mem_read_write | in_WB_mem_or_alu);

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_data_d   = wb_data_q;
        wb_reg_d    = wb_reg_q;
        wb_we_d     = wb_we_q;
        err_d       = err_q;
        hold_reg_d  = hold_reg_q;
        hold_rw_d   = hold_rw_q;
        hold_load_d = hold_load_q;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    req_d       = 1'b1;
                    we_d        = is_store;
                    addr_d      = in_alu_result;
                    wdata_d     = in_data_2;
                    hold_reg_d  = in_reg_write;
                    hold_rw_d   = in_WB_reg_write_signal;
                    hold_load_d = ~is_store;
                    wb_we_d     = 1'b0;
                    cnt_d       = '0;
                    state_d     = ACCESS;
                end else if (in_valid) begin
                    wb_data_d = in_alu_result;
                    wb_reg_d  = in_reg_write;
                    wb_we_d   = in_WB_reg_write_signal;
                end else begin
                    wb_we_d = 1'b0;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    // An ack that arrives on the timeout edge still completes the access.
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                    if (hold_load_q) begin
                        wb_data_d = dmem_rdata;
                        wb_reg_d  = hold_reg_q;
                        wb_we_d   = hold_rw_q;
                    end else begin
                        wb_we_d = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wb_we_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared by async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_data_q   <= '0;
            wb_reg_q    <= '0;
            wb_we_q     <= 1'b0;
            err_q       <= 1'b0;
            hold_reg_q  <= '0;
            hold_rw_q   <= 1'b0;
            hold_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_data_q   <= wb_data_d;
            wb_reg_q    <= wb_reg_d;
            wb_we_q     <= wb_we_d;
            err_q       <= err_d;
            hold_reg_q  <= hold_reg_d;
            hold_rw_q   <= hold_rw_d;
            hold_load_q <= hold_load_d;
        end
    end

    assign stall       = (state_q == ACCESS);
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign out_wb_data = wb_data_q;
    assign out_wb_reg  = wb_reg_q;
    assign out_wb_we   = wb_we_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table plus hand-written multi-cycle sequences.
module tb_mem_wb_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_alu_result;
    logic [7:0] in_data_2;
    logic [2:0] in_reg_write;
    logic       in_MEM_mem_read_write;
    logic       in_WB_mem_or_alu;
    logic       in_WB_reg_write_signal;
    logic       stall;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;
    logic [7:0] out_wb_data;
    logic [2:0] out_wb_reg;
    logic       out_wb_we;
    logic       err;

    int n_total = 0;
    int n_bad   = 0;

    mem_wb_stage #(.TIMEOUT(15)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_alu_result          (in_alu_result),
        .in_data_2              (in_data_2),
        .in_reg_write           (in_reg_write),
        .in_MEM_mem_read_write  (in_MEM_mem_read_write),
        .in_WB_mem_or_alu       (in_WB_mem_or_alu),
        .in_WB_reg_write_signal (in_WB_reg_write_signal),
        .stall                  (stall),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_wdata             (dmem_wdata),
        .dmem_rdata             (dmem_rdata),
        .dmem_ack               (dmem_ack),
        .out_wb_data            (out_wb_data),
        .out_wb_reg             (out_wb_reg),
        .out_wb_we              (out_wb_we),
        .err                    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] alu;
        logic [7:0] d2;
        logic [2:0] rg;
        logic       st;
        logic       ld;
        logic       rw;
        logic       ack;
        logic [7:0] rd;
        logic       e_stall;
        logic       e_req;
        logic       e_we;
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic [7:0] e_wbd;
        logic [2:0] e_wbr;
        logic       e_wbwe;
        logic       e_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] alu, input logic [7:0] d2,
                         input logic [2:0] rg, input logic st, input logic ld, input logic rw);
        in_valid               = v;
        in_alu_result          = alu;
        in_data_2              = d2;
        in_reg_write           = rg;
        in_MEM_mem_read_write  = st;
        in_WB_mem_or_alu       = ld;
        in_WB_reg_write_signal = rw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #3;
    endtask

    initial begin
        int nreq;
        int nwb;
        int idx;
        int ack_cnt;
        logic pre_stall;
        logic [7:0] exp_d[2];
        logic [2:0] exp_r[2];
        logic [7:0] ld_addr[2];
        logic [2:0] ld_reg[2];

        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack   = 1'b0;
        dmem_rdata = 8'h00;
        rst_n      = 1'b1;
        #2;
        do_reset();

        // Reset state
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wbd", out_wb_data, 0);
        chk("rst_wbr", out_wb_reg, 0);
        chk("rst_wbwe", out_wb_we, 0);
        chk("rst_err", err, 0);

        //            v   alu    d2     rg  st ld rw ack rd    | stall req we addr  wdata wbd    wbr wbwe err
        vecs[0]  = '{1, 8'h3C, 8'h00, 5, 0, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h3C, 5, 1, 0}; // ALU op
        vecs[1]  = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h3C, 5, 0, 0}; // bubble
        vecs[2]  = '{1, 8'h10, 8'h00, 2, 0, 1, 1, 0, 8'h00, 1, 1, 0, 8'h10, 8'h00, 8'h3C, 5, 0, 0}; // load accepted
        vecs[3]  = '{1, 8'hFF, 8'hEE, 7, 1, 0, 1, 0, 8'h00, 1, 1, 0, 8'h10, 8'h00, 8'h3C, 5, 0, 0}; // ACCESS, in ignored
        vecs[4]  = '{1, 8'hFF, 8'hEE, 7, 1, 0, 1, 0, 8'h00, 1, 1, 0, 8'h10, 8'h00, 8'h3C, 5, 0, 0};
        vecs[5]  = '{1, 8'hFF, 8'hEE, 7, 1, 0, 1, 1, 8'hA5, 0, 0, 0, 8'h10, 8'h00, 8'hA5, 2, 1, 0}; // ack on 3rd
        vecs[6]  = '{1, 8'h20, 8'h77, 3, 1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h20, 8'h77, 8'hA5, 2, 0, 0}; // store
        vecs[7]  = '{1, 8'h42, 8'h00, 6, 0, 0, 1, 1, 8'h99, 0, 0, 0, 8'h20, 8'h77, 8'hA5, 2, 0, 0}; // ack, no wb
        vecs[8]  = '{1, 8'h42, 8'h00, 6, 0, 0, 1, 0, 8'h00, 0, 0, 0, 8'h20, 8'h77, 8'h42, 6, 1, 0}; // held ALU op
        vecs[9]  = '{1, 8'h30, 8'h11, 1, 1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h30, 8'h11, 8'h42, 6, 0, 0}; // both bits: store
        vecs[10] = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'hEE, 0, 0, 0, 8'h30, 8'h11, 8'h42, 6, 0, 0}; // store ack
        vecs[11] = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h99, 0, 0, 0, 8'h30, 8'h11, 8'h42, 6, 0, 0}; // ack in IDLE
        vecs[12] = '{1, 8'h55, 8'h00, 7, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h30, 8'h11, 8'h55, 7, 0, 0}; // rw=0 ALU op

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].alu, vecs[i].d2, vecs[i].rg, vecs[i].st, vecs[i].ld, vecs[i].rw);
            dmem_ack   = vecs[i].ack;
            dmem_rdata = vecs[i].rd;
            tick();
            chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
            chk($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
            chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_wbd", i), out_wb_data, vecs[i].e_wbd);
            chk($sformatf("v%0d_wbr", i), out_wb_reg, vecs[i].e_wbr);
            chk($sformatf("v%0d_wbwe", i), out_wb_we, vecs[i].e_wbwe);
            chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
        end
        dmem_ack = 1'b0;

        // Back-to-back loads; upstream holds while stalled, memory acks 2 cycles after request
        ld_addr[0] = 8'h40; ld_reg[0] = 3'd1;
        ld_addr[1] = 8'h41; ld_reg[1] = 3'd4;
        exp_d[0] = 8'h40 ^ 8'h5A; exp_r[0] = 3'd1;
        exp_d[1] = 8'h41 ^ 8'h5A; exp_r[1] = 3'd4;
        idx = 0; nwb = 0; ack_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            if (idx < 2) drive(1'b1, ld_addr[idx], 8'h00, ld_reg[idx], 1'b0, 1'b1, 1'b1);
            else         drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
            pre_stall = stall;
            tick();
            if (in_valid && !pre_stall) idx++;
            if (out_wb_we) begin
                if (nwb < 2) begin
                    chk($sformatf("b2b_data%0d", nwb), out_wb_data, exp_d[nwb]);
                    chk($sformatf("b2b_reg%0d", nwb), out_wb_reg, exp_r[nwb]);
                end
                nwb++;
            end
            if (dmem_req) ack_cnt++;
            else          ack_cnt = 0;
            dmem_ack   = (dmem_req && ack_cnt == 2);
            dmem_rdata = dmem_ack ? (dmem_addr ^ 8'h5A) : 8'h00;
        end
        dmem_ack = 1'b0;
        chk("b2b_count", 8'(nwb), 8'd2);
        chk("b2b_accepted", 8'(idx), 8'd2);

        // Ack on the 15th ACCESS cycle wins over timeout
        drive(1'b1, 8'h60, 8'h00, 3'd2, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 14; c++) tick();
        chk("late_req_still", dmem_req, 1);
        chk("late_stall_still", stall, 1);
        dmem_ack = 1'b1; dmem_rdata = 8'hC3;
        tick();
        dmem_ack = 1'b0;
        chk("late_err", err, 0);
        chk("late_wbd", out_wb_data, 8'hC3);
        chk("late_wbr", out_wb_reg, 3'd2);
        chk("late_wbwe", out_wb_we, 1);
        chk("late_req", dmem_req, 0);

        // Timeout: no ack ever; request must stay up exactly 15 cycles
        drive(1'b1, 8'h80, 8'h00, 3'd3, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        nreq = 0;
        while (dmem_req && nreq < 40) begin
            nreq++;
            tick();
        end
        chk("to_req_cycles", 8'(nreq), 8'd15);
        chk("to_err", err, 1);
        chk("to_wbwe", out_wb_we, 0);
        chk("to_stall", stall, 0);
        chk("to_wbd_kept", out_wb_data, 8'hC3);
        tick();
        chk("to_err_sticky", err, 1);

        // Reset asserted mid-ACCESS clears everything immediately
        drive(1'b1, 8'h90, 8'h00, 3'd5, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mid_req_before", dmem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_req", dmem_req, 0);
        chk("mid_stall", stall, 0);
        chk("mid_wbwe", out_wb_we, 0);
        chk("mid_err", err, 0);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 8'h12, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1);
        tick();
        chk("post_wbd", out_wb_data, 8'h12);
        chk("post_wbr", out_wb_reg, 3'd6);
        chk("post_wbwe", out_wb_we, 1);
        chk("post_stall", stall, 0);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_no_late_wb", out_wb_we, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
